rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port (we/wr_addr/wr_data) among NUM_REQ writeback sources: ALU, load unit and multiply/CSR unit.
- Sits between the execute-side writeback sources and register_file.
- Holds a per-register busy scoreboard so decode can stall on RAW/WAW hazards against writes that are still in flight.
- Round-robin grant, one write per cycle, registered output stage.

---
 rtl/rf_wb_arbiter.sv | 118 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin sharing of the single write port among
// NUM_REQ sources, plus a per-register busy scoreboard for decode hazard stalls.
module rf_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_wr_addr,
  output logic [DATA_W-1:0]         rf_wr_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic [ADDR_W-1:0]         chk_rs1,
  input  logic [ADDR_W-1:0]         chk_rs2,
  output logic                      issue_stall,
  output logic [2**ADDR_W-1:0]      busy_vec
);

  localparam int unsigned NumRegs = 2**ADDR_W;
  localparam int unsigned PtrW    = $clog2(NUM_REQ);

  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] upper_req;
  logic [NUM_REQ-1:0] grant;
  logic [PtrW-1:0]    gnt_idx;
  logic               gnt_any;

  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               wr_en;

  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [NumRegs-1:0] busy_q, busy_d;

  // Lowest valid index at or above the pointer wins; otherwise wrap to the lowest valid.
  always_comb begin
    upper_req = '0;
    grant     = '0;
    gnt_idx   = '0;
    gnt_any   = |req_valid;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      upper_req[i] = req_valid[i] && (PtrW'(i) >= ptr_q);
    end
    if (|upper_req) begin
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
        if (upper_req[i]) gnt_idx = PtrW'(i);
      end
    end else begin
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
        if (req_valid[i]) gnt_idx = PtrW'(i);
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to register 0 still handshake but never reach the register file.
  assign wr_en = gnt_any && (sel_addr != '0);

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Set is applied after clear so a same-register set wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[sel_addr] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= wr_en;
      busy_q <= busy_d;
      if (wr_en) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
      end
    end
  end

  assign req_ready   = rst_n ? grant : '0;
  assign rf_we       = we_q;
  assign rf_wr_addr  = addr_q;
  assign rf_wr_data  = data_q;
  assign busy_vec    = busy_q;
  assign issue_stall = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[issue_rd];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected grants/writes are queued by the stimulus
// and popped by a negedge monitor; a small register-file model checks end-to-end data.
module tb_rf_wb_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic             rf_we;
  logic [AW-1:0]    rf_wr_addr;
  logic [DW-1:0]    rf_wr_data;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic [AW-1:0]    chk_rs1;
  logic [AW-1:0]    chk_rs2;
  logic             issue_stall;
  logic [2**AW-1:0] busy_vec;

  int checks = 0;
  int errors = 0;

  logic [NR-1:0]      exp_gnt[$];
  logic [AW+DW-1:0]   exp_wr[$];
  logic [DW-1:0]      regs[2**AW] = '{default: '0};

  rf_wb_arbiter #(
    .NUM_REQ(NR),
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rf_we      (rf_we),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .issue_stall(issue_stall),
    .busy_vec   (busy_vec)
  );

  always #5 clk = ~clk;

  // Register-file model: captures one edge after the arbiter registers the write.
  always @(posedge clk) begin
    if (rf_we && rf_wr_addr != '0) regs[rf_wr_addr] <= rf_wr_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (req_ready != '0) begin
        if (exp_gnt.size() == 0) check("unexpected_grant", 64'(req_ready), 64'd0);
        else check("grant", 64'(req_ready), 64'(exp_gnt.pop_front()));
      end
      if (rf_we) begin
        if (exp_wr.size() == 0) check("unexpected_write", 64'({rf_wr_addr, rf_wr_data}), 64'd0);
        else check("write", 64'({rf_wr_addr, rf_wr_data}), 64'(exp_wr.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic expect_hs(input logic [NR-1:0] g, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic wr);
    exp_gnt.push_back(g);
    if (wr) exp_wr.push_back({a, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    chk_rs1     = '0;
    chk_rs2     = '0;
    #1 rst_n = 1'b0;
    req_valid = '1;
    #1;
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_addr", 64'(rf_wr_addr), 64'd0);
    check("rst_data", 64'(rf_wr_data), 64'd0);
    check("rst_busy", 64'(busy_vec), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // 1: single requester, then data in the register file two edges later
    set_req(1, 1'b1, 5'd5, 16'h1234);
    expect_hs(3'b010, 5'd5, 16'h1234, 1'b1);
    tick();
    set_req(1, 1'b0, '0, '0);
    tick();
    check("t1_reg5", 64'(regs[5]), 64'h1234);
    // bring pointer back to 0
    set_req(2, 1'b1, 5'd6, 16'h0066);
    expect_hs(3'b100, 5'd6, 16'h0066, 1'b1);
    tick();
    set_req(2, 1'b0, '0, '0);

    // 2: all requesters continuously valid -> 0,1,2,0,1,2
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, AW'(i + 1), DW'((i + 1) * 16'h1111));
    for (int k = 0; k < 6; k++) begin
      expect_hs(NR'(1 << (k % 3)), AW'(k % 3 + 1), DW'((k % 3 + 1) * 16'h1111), 1'b1);
      tick();
      check("t2_we", 64'(rf_we), 64'd1);
    end
    req_valid = '0;
    tick();

    // 3: RAW stall cleared by the writeback handshake
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    issue_valid = 1'b0;
    issue_rd    = '0;
    check("t3_busy7", 64'(busy_vec[7]), 64'd1);
    chk_rs1 = 5'd7;
    #1;
    check("t3_stall", 64'(issue_stall), 64'd1);
    set_req(2, 1'b1, 5'd7, 16'h7777);
    expect_hs(3'b100, 5'd7, 16'h7777, 1'b1);
    #1;
    check("t3_stall_pre_hs", 64'(issue_stall), 64'd1);
    tick();
    set_req(2, 1'b0, '0, '0);
    check("t3_stall_post_hs", 64'(issue_stall), 64'd0);
    check("t3_busy7_clr", 64'(busy_vec[7]), 64'd0);
    tick();
    check("t3_reg7", 64'(regs[7]), 64'h7777);
    chk_rs1 = '0;

    // 4: set/clear collisions
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    set_req(0, 1'b1, 5'd9, 16'h0909);
    expect_hs(3'b001, 5'd9, 16'h0909, 1'b1);
    tick();
    set_req(0, 1'b0, '0, '0);
    issue_valid = 1'b0;
    check("t4_same_reg_set_wins", 64'(busy_vec[9]), 64'd1);
    issue_valid = 1'b1;
    issue_rd    = 5'd10;
    tick();
    issue_rd = 5'd9;
    set_req(1, 1'b1, 5'd10, 16'h0a0a);
    expect_hs(3'b010, 5'd10, 16'h0a0a, 1'b1);
    tick();
    set_req(1, 1'b0, '0, '0);
    issue_valid = 1'b0;
    issue_rd    = '0;
    check("t4_busy9", 64'(busy_vec[9]), 64'd1);
    check("t4_busy10", 64'(busy_vec[10]), 64'd0);
    set_req(2, 1'b1, 5'd9, 16'h9999);
    expect_hs(3'b100, 5'd9, 16'h9999, 1'b1);
    tick();
    set_req(2, 1'b0, '0, '0);
    check("t4_busy_all_clr", 64'(busy_vec), 64'd0);
    #1;
    check("t4_zero_no_stall", 64'(issue_stall), 64'd0);

    // 5: write to register 0 handshakes but is dropped
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    tick();
    issue_valid = 1'b0;
    issue_rd    = '0;
    set_req(0, 1'b1, 5'd0, 16'hffff);
    expect_hs(3'b001, 5'd0, 16'hffff, 1'b0);
    tick();
    set_req(0, 1'b0, '0, '0);
    check("t5_we", 64'(rf_we), 64'd0);
    check("t5_busy", 64'(busy_vec), 64'h8);
    tick();
    check("t5_reg0", 64'(regs[0]), 64'd0);

    // 6: async reset with a write registered; pointer restarts at 0 (it was 1)
    set_req(0, 1'b1, 5'd4, 16'hbeef);
    expect_hs(3'b001, 5'd4, 16'hbeef, 1'b1);
    tick();
    check("t6_we_before_rst", 64'(rf_we), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_we", 64'(rf_we), 64'd0);
    check("t6_rst_busy", 64'(busy_vec), 64'd0);
    check("t6_rst_ready", 64'(req_ready), 64'd0);
    exp_wr.delete();
    tick();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_req(2, 1'b1, 5'd8, 16'h8888);
    expect_hs(3'b001, 5'd4, 16'hbeef, 1'b1);
    tick();
    set_req(0, 1'b0, '0, '0);
    expect_hs(3'b100, 5'd8, 16'h8888, 1'b1);
    tick();
    set_req(2, 1'b0, '0, '0);
    tick();
    check("t6_reg4", 64'(regs[4]), 64'hbeef);
    tick();
    check("t6_reg8", 64'(regs[8]), 64'h8888);

    check("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
    check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
